// File: rtl/db_ram_pkg.sv
// Shared types and helpers for the deblocking-filter 1p buffer RAM.
package db_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Widest lane the parity helper accepts; narrower lanes are zero-extended.
    localparam int PAR_MAX_W = 64;

    function automatic int lanes(input int word_w, input int lane_w);
        return word_w / lane_w;
    endfunction

    // Even parity: the returned bit makes the lane plus parity carry an even count of ones.
    function automatic logic lane_parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/db_ram_lane_array.sv
// Storage array with per-lane write enables; the read port is combinational and the
// owning block registers it, so reads complete on the clock edge after the address.
module db_ram_lane_array
    import db_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 3,
    parameter int LANES      = 16,
    parameter int CELL_W     = 8
) (
    input  logic                    clk,
    input  logic [LANES-1:0]        i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [LANES*CELL_W-1:0] i_wdata,
    output logic [LANES*CELL_W-1:0] o_rdata
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [LANES*CELL_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (i_we[k]) begin
                r_mem[i_addr][k*CELL_W +: CELL_W] <= i_wdata[k*CELL_W +: CELL_W];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/db_ram_1p_mask.sv
// Single-port lane-masked buffer RAM with registered read, output enable and a clear
// sequencer. Define DB_RAM_PARITY_EN to store per-lane even parity and drive err_o.
module db_ram_1p_mask
    import db_ram_pkg::*;
#(
    parameter int                    WORD_WIDTH = 128,
    parameter int                    ADDR_WIDTH = 3,
    parameter int                    LANE_WIDTH = 8,
    parameter logic [LANE_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   LANES      = lanes(WORD_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cen_i,
    input  logic                  wen_i,
    input  logic                  oen_i,
    input  logic [LANES-1:0]      bwen_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic                  init_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  busy_o,
    output logic                  err_o
);

`ifdef DB_RAM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int CELL_W = LANE_WIDTH + PAR_W;
    localparam int ARR_W  = LANES * CELL_W;

    if (WORD_WIDTH % LANE_WIDTH != 0) begin : g_bad_width
        $error("db_ram_1p_mask: WORD_WIDTH must be a multiple of LANE_WIDTH");
    end

    state_t                r_state;
    state_t                w_state_nx;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nx;
    logic [WORD_WIDTH-1:0] r_rd;
    logic                  w_clear;
    logic                  w_rd_en;
    logic [LANES-1:0]      w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ARR_W-1:0]      w_wdata;
    logic [ARR_W-1:0]      w_rdata;
    logic [WORD_WIDTH-1:0] w_rword;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // A clear request always restarts the sweep from address 0, even mid-clear.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (init_i) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                if (init_i) begin
                    w_state_nx = ST_CLEAR;
                    w_cnt_nx   = '0;
                end
            end
        endcase
    end

    assign w_clear = (r_state == ST_CLEAR);
    assign w_rd_en = !w_clear && !cen_i && wen_i;

    always_comb begin
        w_we    = '0;
        w_addr  = addr_i;
        w_wdata = '0;
        if (w_clear) begin
            w_we   = '1;
            w_addr = r_cnt;
        end else if (!cen_i && !wen_i) begin
            w_we = ~bwen_i;
        end
        for (int k = 0; k < LANES; k++) begin
            w_wdata[k*CELL_W +: LANE_WIDTH] = w_clear ? INIT_VALUE
                                                      : data_i[k*LANE_WIDTH +: LANE_WIDTH];
`ifdef DB_RAM_PARITY_EN
            w_wdata[k*CELL_W + LANE_WIDTH] =
                lane_parity(PAR_MAX_W'(w_wdata[k*CELL_W +: LANE_WIDTH]));
`endif
        end
    end

    db_ram_lane_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LANES      (LANES),
        .CELL_W     (CELL_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_rword = '0;
        for (int k = 0; k < LANES; k++) begin
            w_rword[k*LANE_WIDTH +: LANE_WIDTH] = w_rdata[k*CELL_W +: LANE_WIDTH];
        end
    end

    // Read register: loads only on an idle-state read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd <= '0;
        end else if (w_rd_en) begin
            r_rd <= w_rword;
        end
    end

`ifdef DB_RAM_PARITY_EN
    logic w_perr;
    logic r_err;

    always_comb begin
        w_perr = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            w_perr = w_perr | (^w_rdata[k*CELL_W +: CELL_W]);
        end
    end

    // Sticky; a clear request or an active sweep wipes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (init_i || w_clear) begin
            r_err <= 1'b0;
        end else if (w_rd_en && w_perr) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign data_o = oen_i ? '0 : r_rd;
    assign busy_o = w_clear;

endmodule
